sram_controller: RTL and testbench
==================================

SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, meaning extra SRAM cycles held per halfword phase (range 0..7).
REQ-002 SHALL have parameter BASE_ADDR, default 1024, meaning the byte address mapped to SRAM halfword 0.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous and active-low.
REQ-005 SHALL have port wr_en, input, 1, 32-bit store request from the MEM stage.
REQ-006 SHALL have port rd_en, input, 1, 32-bit load request from the MEM stage.
REQ-007 SHALL have port address, input, 32, byte address of the request; bits [1:0] are ignored.
REQ-008 SHALL have port wdata, input, 32, store data.
REQ-009 SHALL have port rdata, output, 32, load data, valid when ready=1 after a read.
REQ-010 SHALL have port ready, output, 1, 0 means stall (pipeline freeze).
REQ-011 SHALL have port sram_dq, inout, 16, SRAM data bus.
REQ-012 SHALL have port sram_address, output, 18, SRAM halfword address.
REQ-013 SHALL have ports SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N, output, 1 each, active-low SRAM controls.

Function
REQ-014 SHALL use FSM states IDLE, LOW, HIGH, DONE.
REQ-015 SHALL compute phys = address - BASE_ADDR (32-bit wrap); sram_address = {phys[18:2], h}, where h=0 in LOW and h=1 in HIGH.
REQ-016 SHALL, in IDLE with wr_en or rd_en, drive ready=0 combinationally in that cycle, latch address/wdata/operation, and go to LOW.
REQ-017 SHALL give wr_en priority when wr_en and rd_en are both 1 (operation = write).
REQ-018 SHALL hold LOW and then HIGH for WAIT_CYCLES+1 cycles each, using a 3-bit phase counter cleared on every phase entry.
REQ-019 SHALL, for a read, capture sram_dq into rdata[15:0] on the last LOW cycle and into rdata[31:16] on the last HIGH cycle.
REQ-020 SHALL, for a write, drive wdata[15:0] in LOW and wdata[31:16] in HIGH with SRAM_WE_N=0; otherwise sram_dq is high-Z and SRAM_WE_N=1.
REQ-021 SHALL drive ready=1 in DONE for exactly one cycle and return to IDLE, ignoring any request present in that DONE cycle.
REQ-022 SHALL keep ready=0 for 1+2*(WAIT_CYCLES+1) consecutive cycles per SRAM access (5 cycles at default).
REQ-023 SHALL drive ready=1 in IDLE with no request, and hold rdata at its last captured value.
REQ-024 SHALL tie SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, and SRAM_OE_N to 0.
REQ-025 SHALL ignore changes to address/wdata/enables while not in IDLE; latched values are used.

Reset
REQ-026 SHALL, while rst=0, force the state to IDLE, the counter to 0, rdata=0, SRAM_WE_N=1, sram_dq high-Z, and sram_address=0; ready=1 if no request is present.
REQ-027 SHALL abort an in-flight access on reset without completing the second halfword; after release, a new request starts in LOW.

Configuration
REQ-028 SHALL, with macro SRAM_CTRL_RDBUF_EN defined, include a one-entry read buffer (valid, 17-bit word tag, 32-bit data).
REQ-029 SHALL, with SRAM_CTRL_RDBUF_EN, fill the buffer on read completion; a read in IDLE whose phys[18:2] matches a valid tag keeps ready=1, drives rdata from the buffer in the same cycle, and starts no SRAM access.
REQ-030 SHALL, with SRAM_CTRL_RDBUF_EN, invalidate the buffer when a write to the matching tag is accepted; on reset, valid=0.
REQ-031 SHALL, without SRAM_CTRL_RDBUF_EN, send every read to SRAM and contain no buffer logic.

Structure
REQ-032 SHALL place the state enum, the WAIT_CYCLES/BASE_ADDR defaults, and the width constants (17-bit tag, 18-bit SRAM address) in package sram_ctrl_pkg.
REQ-033 SHALL implement the read buffer as the sub-module sram_ctrl_rdbuf, instantiated only under SRAM_CTRL_RDBUF_EN.

Verification
REQ-034 Write test: wr_en, address=1024, wdata=0xDEADBEEF. SRAM halfword 0 = 0xBEEF and halfword 1 = 0xDEAD; ready=0 for 5 cycles, then 1.
REQ-035 Readback test: rd_en, address=1024 after REQ-034. rdata=0xDEADBEEF in the DONE cycle with ready=1; SRAM_WE_N stays 1 throughout.
REQ-036 Priority test: wr_en=rd_en=1, address=1028, wdata=0x12345678. A write occurs (halfwords 2/3 = 0x5678/0x1234); a subsequent read returns 0x12345678.
REQ-037 Reset test: assert rst=0 on the second cycle of HIGH during a write. ready=1, SRAM_WE_N=1, dq high-Z, and the state is IDLE immediately (asynchronous).
REQ-038 WAIT_CYCLES test: set WAIT_CYCLES=3 and issue one read. ready=0 for exactly 9 cycles.
REQ-039 Read buffer test (SRAM_CTRL_RDBUF_EN): two reads of 1024 back to back. The second read has zero stall cycles; then write 1024 and read again. The read takes a 5-cycle stall and returns the new data.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the 32-bit to 16-bit SRAM bridge.
package sram_ctrl_pkg;
  localparam int unsigned WAIT_CYCLES_DEF = 1;
  localparam logic [31:0] BASE_ADDR_DEF   = 32'd1024;
  localparam int          TAG_W           = 17;
  localparam int          SADDR_W         = 18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/sram_ctrl_rdbuf.sv
// One-entry read buffer holding the last 32-bit word read from SRAM.
// Only instantiated when SRAM_CTRL_RDBUF_EN is defined.
module sram_ctrl_rdbuf
  import sram_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_fill,
  input  logic [TAG_W-1:0] i_fill_tag,
  input  logic [31:0]      i_fill_data,
  input  logic             i_inval,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_hit,
  output logic [31:0]      o_data
);
  logic             r_valid;
  logic [TAG_W-1:0] r_tag;
  logic [31:0]      r_data;

  assign o_hit  = r_valid && (r_tag == i_tag);
  assign o_data = r_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (i_fill) begin
      r_valid <= 1'b1;
      r_tag   <= i_fill_tag;
      r_data  <= i_fill_data;
    end else if (i_inval && o_hit) begin
      r_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/sram_controller.sv
// Splits each 32-bit MEM-stage load/store into two 16-bit SRAM phases, stalling via ready.
// Optional read buffer enabled by defining SRAM_CTRL_RDBUF_EN.
//
// state | meaning
// IDLE  | ready=1, waiting for wr_en/rd_en; request latched here
// LOW   | halfword 0 (h=0) held for WAIT_CYCLES+1 cycles
// HIGH  | halfword 1 (h=1) held for WAIT_CYCLES+1 cycles
// DONE  | ready=1 for one cycle, rdata complete, requests ignored
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  inout  wire  [15:0]        sram_dq,
  output logic [SADDR_W-1:0] sram_address,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_WE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N
);
  localparam logic [2:0] LAST_CNT = 3'(WAIT_CYCLES);

  state_t           r_state, w_next;
  logic [2:0]       r_cnt;
  logic [TAG_W-1:0] r_word;
  logic [31:0]      r_wdata;
  logic             r_is_wr;
  logic [31:0]      r_rdata;

  logic [31:0]      w_phys;
  logic [TAG_W-1:0] w_tag;
  logic             w_last, w_half, w_drive, w_start, w_hit;
  logic             w_unused;

  assign w_phys   = address - BASE_ADDR;
  assign w_tag    = w_phys[18:2];
  assign w_unused = ^{w_phys[31:19], w_phys[1:0]};

  assign w_last  = (r_cnt == LAST_CNT);
  assign w_half  = (r_state == HIGH);
  assign w_drive = r_is_wr && ((r_state == LOW) || (r_state == HIGH));

  assign SRAM_UB_N    = 1'b0;
  assign SRAM_LB_N    = 1'b0;
  assign SRAM_CE_N    = 1'b0;
  assign SRAM_OE_N    = 1'b0;
  assign SRAM_WE_N    = ~w_drive;
  assign sram_address = {r_word, w_half};
  assign sram_dq      = w_drive ? (w_half ? r_wdata[31:16] : r_wdata[15:0]) : 16'hzzzz;

`ifdef SRAM_CTRL_RDBUF_EN
  logic        w_buf_hit;
  logic [31:0] w_buf_data;

  sram_ctrl_rdbuf u_rdbuf (
    .clk         (clk),
    .rst         (rst),
    .i_fill      ((r_state == DONE) && !r_is_wr),
    .i_fill_tag  (r_word),
    .i_fill_data (r_rdata),
    .i_inval     ((r_state == IDLE) && wr_en),
    .i_tag       (w_tag),
    .o_hit       (w_buf_hit),
    .o_data      (w_buf_data)
  );

  // A buffered read completes in IDLE without touching SRAM.
  assign w_hit = (r_state == IDLE) && rd_en && !wr_en && w_buf_hit;
  assign rdata = w_hit ? w_buf_data : r_rdata;
`else
  assign w_hit = 1'b0;
  assign rdata = r_rdata;
`endif

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    ready   = 1'b0;
    case (r_state)
      IDLE: begin
        ready = 1'b1;
        if (wr_en || (rd_en && !w_hit)) begin
          ready   = 1'b0;
          w_start = 1'b1;
          w_next  = LOW;
        end
      end
      LOW:  if (w_last) w_next = HIGH;
      HIGH: if (w_last) w_next = DONE;
      DONE: begin
        ready  = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
      r_word  <= '0;
      r_wdata <= '0;
      r_is_wr <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (((r_state == LOW) || (r_state == HIGH)) && (w_next == r_state))
        r_cnt <= r_cnt + 3'd1;
      else
        r_cnt <= 3'd0;
      if (w_start) begin
        r_word  <= w_tag;
        r_wdata <= wdata;
        r_is_wr <= wr_en;
      end
      // Each halfword is sampled at the end of its phase, after the wait states.
      if (!r_is_wr && w_last) begin
        if (r_state == LOW)  r_rdata[15:0]  <= sram_dq;
        if (r_state == HIGH) r_rdata[31:16] <= sram_dq;
      end
    end
  end
endmodule

// File: tb/tb_sram_controller.sv
// Directed self-checking bench for sram_controller with a behavioural 16-bit SRAM.
// Read-buffer expectations switch on SRAM_CTRL_RDBUF_EN.
`timescale 1ns/1ps
module tb_sram_controller;
  import sram_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, wr_en, rd_en, ready;
  logic [31:0] address, wdata, rdata;
  wire  [15:0] sram_dq;
  logic [17:0] sram_address;
  logic        ub_n, lb_n, we_n, ce_n, oe_n;

  logic        rd_en3, ready3;
  logic        wr_en3 = 1'b0;
  logic [31:0] address3, rdata3;
  logic [31:0] wdata3 = 32'h0;
  wire  [15:0] sram_dq3;
  logic [17:0] sram_address3;
  logic        ub3, lb3, we3, ce3, oe3;

  logic [15:0] mem [0:255];

  sram_controller dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address), .wdata(wdata),
    .rdata(rdata), .ready(ready), .sram_dq(sram_dq), .sram_address(sram_address),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n)
  );

  sram_controller #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .wr_en(wr_en3), .rd_en(rd_en3), .address(address3), .wdata(wdata3),
    .rdata(rdata3), .ready(ready3), .sram_dq(sram_dq3), .sram_address(sram_address3),
    .SRAM_UB_N(ub3), .SRAM_LB_N(lb3), .SRAM_WE_N(we3), .SRAM_CE_N(ce3), .SRAM_OE_N(oe3)
  );

  assign sram_dq  = we_n ? mem[sram_address[7:0]] : 16'hzzzz;
  always @(posedge clk) if (!we_n) mem[sram_address[7:0]] <= sram_dq;
  // The second SRAM returns a pattern derived from its address.
  assign sram_dq3 = we3 ? {8'h5A, sram_address3[7:0]} : 16'hzzzz;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                        output int stall, output logic [31:0] rd, output logic we_seen);
    stall   = 0;
    we_seen = 1'b0;
    @(negedge clk);
    wr_en = w; rd_en = r; address = a; wdata = d;
    #1;
    while (!ready && stall < 40) begin
      stall++;
      if (!we_n) we_seen = 1'b1;
      @(negedge clk);
      wr_en = 1'b0; rd_en = 1'b0; address = 32'hFFFF_FFF0; wdata = 32'h5555_AAAA;
      #1;
    end
    rd = rdata;
    if (!we_n) we_seen = 1'b1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  int          stall;
  logic [31:0] rd;
  logic        we_seen;
  int          exp_hit_stall;

  initial begin
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; address = 32'h0; wdata = 32'h0;
    rd_en3 = 1'b0; address3 = 32'h0;
`ifdef SRAM_CTRL_RDBUF_EN
    exp_hit_stall = 0;
`else
    exp_hit_stall = 5;
`endif
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_ready", {31'd0, ready}, 32'd1);
    check_eq("rst_rdata", rdata, 32'h0);
    check_eq("rst_we_n", {31'd0, we_n}, 32'd1);
    check_eq("rst_saddr", {14'd0, sram_address}, 32'd0);
    check_eq("rst_ties", {28'd0, ub_n, lb_n, ce_n, oe_n}, 32'd0);
    check_eq("rst_state", 32'(dut.r_state), 32'(IDLE));
    @(negedge clk) rst = 1'b1;

    access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, stall, rd, we_seen);
    check_eq("wr_stall", stall, 32'd5);
    check_eq("wr_we_seen", {31'd0, we_seen}, 32'd1);
    check_eq("wr_mem0", {16'd0, mem[0]}, 32'h0000BEEF);
    check_eq("wr_mem1", {16'd0, mem[1]}, 32'h0000DEAD);

    access(1'b0, 1'b1, 32'd1024, 32'h0, stall, rd, we_seen);
    check_eq("rd_stall", stall, 32'd5);
    check_eq("rd_data", rd, 32'hDEADBEEF);
    check_eq("rd_we_quiet", {31'd0, we_seen}, 32'd0);

    access(1'b1, 1'b1, 32'd1028, 32'h12345678, stall, rd, we_seen);
    check_eq("prio_stall", stall, 32'd5);
    check_eq("prio_mem2", {16'd0, mem[2]}, 32'h00005678);
    check_eq("prio_mem3", {16'd0, mem[3]}, 32'h00001234);
    access(1'b0, 1'b1, 32'd1028, 32'h0, stall, rd, we_seen);
    check_eq("prio_rd_stall", stall, 32'd5);
    check_eq("prio_rd_data", rd, 32'h12345678);

    // Abort a write during the second HIGH cycle.
    @(negedge clk);
    wr_en = 1'b1; address = 32'd1032; wdata = 32'hCAFEF00D;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("abort_pre_we_n", {31'd0, we_n}, 32'd0);
    check_eq("abort_pre_saddr", {14'd0, sram_address}, 32'd5);
    rst = 1'b0;
    #1;
    check_eq("abort_ready", {31'd0, ready}, 32'd1);
    check_eq("abort_we_n", {31'd0, we_n}, 32'd1);
    check_eq("abort_state", 32'(dut.r_state), 32'(IDLE));
    check_eq("abort_saddr", {14'd0, sram_address}, 32'd0);
    check_eq("abort_dq_released", {16'd0, sram_dq}, 32'h0000BEEF);
    check_eq("abort_rdata", rdata, 32'h0);
    check_eq("abort_mem4", {16'd0, mem[4]}, 32'h0000F00D);
    @(negedge clk) rst = 1'b1;

    access(1'b0, 1'b1, 32'd1024, 32'h0, stall, rd, we_seen);
    check_eq("post_rst_stall", stall, 32'd5);
    check_eq("post_rst_data", rd, 32'hDEADBEEF);

    access(1'b0, 1'b1, 32'd1024, 32'h0, stall, rd, we_seen);
    check_eq("reread_stall", stall, exp_hit_stall);
    check_eq("reread_data", rd, 32'hDEADBEEF);
    @(negedge clk);
    #1;
    check_eq("idle_hold_rdata", rdata, 32'hDEADBEEF);
    check_eq("idle_ready", {31'd0, ready}, 32'd1);

    access(1'b1, 1'b0, 32'd1024, 32'h0BADF00D, stall, rd, we_seen);
    check_eq("wr2_stall", stall, 32'd5);
    access(1'b0, 1'b1, 32'd1024, 32'h0, stall, rd, we_seen);
    check_eq("rd_after_wr_stall", stall, 32'd5);
    check_eq("rd_after_wr_data", rd, 32'h0BADF00D);

    // WAIT_CYCLES=3 instance: 1 + 2*4 stall cycles.
    stall = 0;
    @(negedge clk);
    rd_en3 = 1'b1; address3 = 32'd1032;
    #1;
    while (!ready3 && stall < 40) begin
      stall++;
      @(negedge clk);
      rd_en3 = 1'b0; address3 = 32'h0;
      #1;
    end
    rd_en3 = 1'b0;
    check_eq("wc3_stall", stall, 32'd9);
    check_eq("wc3_data", rdata3, 32'h5A055A04);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
